// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and sizing helper for the point-operation accelerator
package acc_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {MODE_INV, MODE_THR, MODE_COPY, MODE_BRIGHT} mode_t;

  typedef logic [31:0] word_t;
  typedef logic [15:0] halfword_t;

  function automatic int calc_nwords(int img_w, int img_h, int pix_w, int word_w);
    return (img_w * img_h * pix_w) / word_w;
  endfunction

endpackage

// File: rtl/acc_lane_op.sv
// rtl/acc_lane_op.sv - combinational single-pixel operator (invert/threshold/copy/brighten)
module acc_lane_op #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] p,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] q
);
  import acc_pkg::*;

  localparam logic [PIX_W-1:0] MAX = '1;

  logic [PIX_W:0] sum;

  always_comb begin
    // one extra bit so brighten saturates instead of wrapping
    sum = {1'b0, p} + {1'b0, thresh};
    q   = p;
    case (mode_t'(mode))
      MODE_INV:    q = MAX - p;
      MODE_THR:    q = (p >= thresh) ? MAX : '0;
      MODE_COPY:   q = p;
      MODE_BRIGHT: q = sum[PIX_W] ? MAX : sum[PIX_W-1:0];
      default:     q = p;
    endcase
  end

endmodule

// File: rtl/acc_pointop.sv
// rtl/acc_pointop.sv - streams a packed image through a per-pixel op into a second region
// Optional cycle counter port enabled by ACC_CYCLE_COUNT_EN.
module acc_pointop #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int PIX_W    = 8,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25344
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] dataR,
  output logic [WORD_W-1:0] dataW,
  output logic              en,
  output logic              we,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  thresh,
  output logic              busy,
  output logic              finish
`ifdef ACC_CYCLE_COUNT_EN
  ,
  output logic [31:0]       cycles
`endif
);
  import acc_pkg::*;

  localparam int NWORDS = calc_nwords(IMG_W, IMG_H, PIX_W, WORD_W);
  localparam int LANES  = WORD_W / PIX_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  if ((IMG_W * PIX_W) % WORD_W != 0 || WORD_W % PIX_W != 0) begin : g_chk_pack
    $error("acc_pointop: image row must pack into whole words");
  end
  if (longint'(SRC_BASE) + NWORDS > (longint'(1) << ADDR_W) ||
      longint'(DST_BASE) + NWORDS > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("acc_pointop: image region exceeds address space");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thresh_q;
  logic [WORD_W-1:0] result;
  logic             last;

  assign last = (idx == IDX_W'(NWORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode;
          thresh_q <= thresh;
          idx      <= '0;
          state    <= READ;
        end
        READ:  state <= WRITE;
        WRITE: if (last) state <= DONE;
               else begin
                 idx   <= idx + 1'b1;
                 state <= READ;
               end
        DONE:  if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_lane_op #(.PIX_W(PIX_W)) u_op (
      .p      (dataR[k*PIX_W +: PIX_W]),
      .mode   (mode_q),
      .thresh (thresh_q),
      .q      (result[k*PIX_W +: PIX_W])
    );
  end

  // outputs decode from state so an asynchronous reset silences them at once
  always_comb begin
    en     = 1'b0;
    we     = 1'b0;
    busy   = 1'b0;
    finish = 1'b0;
    addr   = '0;
    dataW  = '0;
    case (state)
      READ: begin
        en   = 1'b1;
        busy = 1'b1;
        addr = ADDR_W'(SRC_BASE) + ADDR_W'(idx);
      end
      WRITE: begin
        en    = 1'b1;
        we    = 1'b1;
        busy  = 1'b1;
        addr  = ADDR_W'(DST_BASE) + ADDR_W'(idx);
        dataW = result;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

`ifdef ACC_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (state == IDLE && start) begin
      cycles <= '0;
    end else if ((state == READ || state == WRITE) && cycles != '1) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

endmodule
